// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if: byte input, key state and event FIFO signals of the PS/2 key tracker.
// master = receiver/consumer side, slave = tracker.
interface ps2_key_tracker_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       key_l_up;
    logic       key_l_dn;
    logic       key_r_up;
    logic       key_r_dn;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_valid;
    logic       evt_ready;
    logic       overflow;
    logic       prefix_timeout;

    modport master (
        output rx_data, rx_valid, evt_ready,
        input  key_l_up, key_l_dn, key_r_up, key_r_dn,
        input  evt_code, evt_ext, evt_break, evt_valid, overflow, prefix_timeout
    );

    modport slave (
        input  rx_data, rx_valid, evt_ready,
        output key_l_up, key_l_dn, key_r_up, key_r_dn,
        output evt_code, evt_ext, evt_break, evt_valid, overflow, prefix_timeout
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: decodes E0/F0-prefixed scan codes into events, tracks the four paddle keys, queues events in a FWFT FIFO.
// Define PS2_TIMEOUT_EN to discard a partial prefix after TIMEOUT_CYCLES idle cycles.
module ps2_key_tracker #(
    parameter int         FIFO_DEPTH     = 4,
    parameter logic [7:0] CODE_L_UP      = 8'h1D,
    parameter logic [7:0] CODE_L_DN      = 8'h1B,
    parameter logic [7:0] CODE_R_UP      = 8'h75,
    parameter logic [7:0] CODE_R_DN      = 8'h72,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input logic              CLOCK_50,
    input logic              reset,
    ps2_key_tracker_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = FIFO_DEPTH[AW:0];

    // bit0 = E0 seen, bit1 = F0 seen
    typedef enum logic [1:0] {IDLE = 2'b00, EXT = 2'b01, BRK = 2'b10, EXT_BRK = 2'b11} state_t;

    state_t        state, state_nx;
    logic          emit, emit_ext, emit_brk;
    logic          is_e0, is_f0, is_ctrl, timeout_hit;
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   count;
    logic          push, pop, full;
    logic [3:0]    keys;
    logic          ovf, pto;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("ps2_key_tracker: unsupported parameter values");
    end

    assign is_e0   = bus.rx_data == 8'hE0;
    assign is_f0   = bus.rx_data == 8'hF0;
    assign is_ctrl = bus.rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        emit_ext = state[0];
        emit_brk = state[1];
        if (bus.rx_valid) begin
            if (is_ctrl) state_nx = IDLE;
            else if (is_e0) state_nx = state_t'({state[1], 1'b1});
            else if (is_f0) state_nx = state_t'({1'b1, state[0]});
            else begin
                emit     = 1'b1;
                state_nx = IDLE;
            end
        end else if (timeout_hit) state_nx = IDLE;
    end

    always_ff @(posedge CLOCK_50)
        if (reset) state <= IDLE;
        else state <= state_nx;

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;

    assign timeout_hit = !bus.rx_valid && state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge CLOCK_50)
        if (reset || bus.rx_valid || state == IDLE || timeout_hit) to_cnt <= '0;
        else to_cnt <= to_cnt + 1'b1;
`else
    assign timeout_hit = 1'b0;
`endif

    assign full = count == DEPTH;
    assign pop  = count != '0 && bus.evt_ready;
    assign push = emit && (!full || pop);

    always_ff @(posedge CLOCK_50)
        if (push) mem[wp] <= {bus.rx_data, emit_ext, emit_brk};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            keys  <= '0;
            ovf   <= 1'b0;
            pto   <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            ovf   <= ovf | (emit && full && !pop);
            pto   <= timeout_hit;
            if (emit && bus.rx_data == CODE_L_UP && !emit_ext) keys[0] <= !emit_brk;
            if (emit && bus.rx_data == CODE_L_DN && !emit_ext) keys[1] <= !emit_brk;
            if (emit && bus.rx_data == CODE_R_UP && emit_ext) keys[2] <= !emit_brk;
            if (emit && bus.rx_data == CODE_R_DN && emit_ext) keys[3] <= !emit_brk;
        end
    end

    assign bus.key_l_up       = keys[0];
    assign bus.key_l_dn       = keys[1];
    assign bus.key_r_up       = keys[2];
    assign bus.key_r_dn       = keys[3];
    assign bus.evt_valid      = count != '0;
    assign bus.evt_code       = bus.evt_valid ? mem[rp][9:2] : 8'h00;
    assign bus.evt_ext        = bus.evt_valid && mem[rp][1];
    assign bus.evt_break      = bus.evt_valid && mem[rp][0];
    assign bus.overflow       = ovf;
    assign bus.prefix_timeout = pto;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed scan-code sequences checked against a queue-based event model and literal expectations.
module tb_ps2_key_tracker;
    localparam int DEPTH = 4;
    localparam int TO    = 50000;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    logic started  = 1'b0;
    int   n_chk    = 0;
    int   n_pass   = 0;

    ps2_key_tracker_if bus();

    ps2_key_tracker #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50(CLOCK_50),
        .reset(reset),
        .bus(bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: prefix flags, event queue, key table, sticky overflow, timeout pulse
    logic [9:0] q[$];
    logic [3:0] m_keys;
    logic       m_ov, m_to, m_ext, m_brk;
    int         m_cnt;
    logic       e_go, e_pop, e_ext, e_brk;
    logic [7:0] e_code;
    logic [7:0] kc[4] = '{8'h1D, 8'h1B, 8'h75, 8'h72};
    logic       kx[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    always @(posedge CLOCK_50) begin
        m_to = 1'b0;
        if (reset) begin
            q.delete();
            m_keys = '0;
            m_ov   = 1'b0;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
            m_cnt  = 0;
        end else begin
            e_go  = 1'b0;
            e_pop = q.size() != 0 && bus.evt_ready;
            if (bus.rx_valid) begin
                m_cnt = 0;
                if (bus.rx_data inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) {m_ext, m_brk} = 2'b00;
                else if (bus.rx_data == 8'hE0) m_ext = 1'b1;
                else if (bus.rx_data == 8'hF0) m_brk = 1'b1;
                else begin
                    e_go   = 1'b1;
                    e_code = bus.rx_data;
                    e_ext  = m_ext;
                    e_brk  = m_brk;
                    {m_ext, m_brk} = 2'b00;
                end
            end
`ifdef PS2_TIMEOUT_EN
            else if (m_ext || m_brk) begin
                if (m_cnt == TO - 1) begin
                    {m_ext, m_brk} = 2'b00;
                    m_to  = 1'b1;
                    m_cnt = 0;
                end else m_cnt++;
            end
`endif
            if (e_pop) void'(q.pop_front());
            if (e_go) begin
                if (q.size() < DEPTH) q.push_back({e_code, e_ext, e_brk});
                else m_ov = 1'b1;
                for (int i = 0; i < 4; i++)
                    if (e_code == kc[i] && e_ext == kx[i]) m_keys[i] = !e_brk;
            end
        end
    end

    always @(negedge CLOCK_50)
        if (started && !reset) begin
            chk("model_keys", {bus.key_r_dn, bus.key_r_up, bus.key_l_dn, bus.key_l_up}, m_keys);
            chk("model_evt_valid", bus.evt_valid, q.size() != 0);
            chk("model_overflow", bus.overflow, m_ov);
            chk("model_prefix_timeout", bus.prefix_timeout, m_to);
            if (q.size() != 0) chk("model_head", {bus.evt_code, bus.evt_ext, bus.evt_break}, q[0]);
        end

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge CLOCK_50);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic pop_head();
        bus.evt_ready = 1'b1;
        @(posedge CLOCK_50);
        #1 bus.evt_ready = 1'b0;
    endtask

    task automatic head(input string name, input logic [7:0] c, input logic x, input logic b);
        chk({name, "_valid"}, bus.evt_valid, 1'b1);
        chk(name, {bus.evt_code, bus.evt_ext, bus.evt_break}, {c, x, b});
    endtask

    int pulses;

    initial begin
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.evt_ready = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        started = 1'b1;
        chk("rst_keys", {bus.key_r_dn, bus.key_r_up, bus.key_l_dn, bus.key_l_up}, 4'h0);
        chk("rst_evt_valid", bus.evt_valid, 1'b0);
        chk("rst_evt", {bus.evt_code, bus.evt_ext, bus.evt_break}, 10'h0);
        chk("rst_overflow", bus.overflow, 1'b0);
        chk("rst_timeout", bus.prefix_timeout, 1'b0);

        send(8'h1D);
        chk("w_make_key", bus.key_l_up, 1'b1);
        head("w_make_evt", 8'h1D, 1'b0, 1'b0);
        pop_head();
        chk("w_popped", bus.evt_valid, 1'b0);

        send(8'hF0); send(8'h1D);
        chk("w_break_key", bus.key_l_up, 1'b0);
        head("w_break_evt", 8'h1D, 1'b0, 1'b1);
        pop_head();

        send(8'hE0); send(8'h75);
        chk("rup_make_key", bus.key_r_up, 1'b1);
        head("rup_make_evt", 8'h75, 1'b1, 1'b0);
        pop_head();
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("rup_break_key", bus.key_r_up, 1'b0);
        head("rup_break_evt", 8'h75, 1'b1, 1'b1);
        pop_head();

        send(8'h1B);
        chk("s_make_key", bus.key_l_dn, 1'b1);
        pop_head();
        send(8'hE0); send(8'h72);
        chk("rdn_make_key", bus.key_r_dn, 1'b1);
        pop_head();
        send(8'hE0); send(8'h1D);
        chk("ext_1d_no_key", bus.key_l_up, 1'b0);
        head("ext_1d_evt", 8'h1D, 1'b1, 1'b0);
        pop_head();
        send(8'h75);
        chk("plain_75_no_key", bus.key_r_up, 1'b0);
        head("plain_75_evt", 8'h75, 1'b0, 1'b0);
        pop_head();

        foreach (kc[i]) ;
        send(8'h1D); send(8'h1B); send(8'h16); send(8'h1E); send(8'h26);
        chk("ovf_set", bus.overflow, 1'b1);
        chk("ovf_key_l_up", bus.key_l_up, 1'b1);
        head("ovf_h0", 8'h1D, 1'b0, 1'b0); pop_head();
        head("ovf_h1", 8'h1B, 1'b0, 1'b0); pop_head();
        head("ovf_h2", 8'h16, 1'b0, 1'b0); pop_head();
        head("ovf_h3", 8'h1E, 1'b0, 1'b0); pop_head();
        chk("ovf_drained", bus.evt_valid, 1'b0);

        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        bus.rx_data   = 8'h2E;
        bus.rx_valid  = 1'b1;
        bus.evt_ready = 1'b1;
        @(posedge CLOCK_50);
        #1 bus.rx_valid = 1'b0;
        bus.evt_ready = 1'b0;
        head("full_pp_h0", 8'h1E, 1'b0, 1'b0); pop_head();
        head("full_pp_h1", 8'h26, 1'b0, 1'b0); pop_head();
        head("full_pp_h2", 8'h25, 1'b0, 1'b0); pop_head();
        head("full_pp_h3", 8'h2E, 1'b0, 1'b0); pop_head();
        chk("full_pp_drained", bus.evt_valid, 1'b0);

        send(8'hE0); send(8'hAA);
        chk("ctrl_no_evt", bus.evt_valid, 1'b0);
        send(8'h75);
        head("ctrl_evt", 8'h75, 1'b0, 1'b0);
        chk("ctrl_key_r_up", bus.key_r_up, 1'b0);
        pop_head();

        send(8'hF0); send(8'hE0); send(8'h72);
        chk("brk_ext_key", bus.key_r_dn, 1'b0);
        head("brk_ext_evt", 8'h72, 1'b1, 1'b1);
        pop_head();

        send(8'hF0); send(8'hF0); send(8'h1B);
        chk("dbl_f0_key", bus.key_l_dn, 1'b0);
        head("dbl_f0_evt", 8'h1B, 1'b0, 1'b1);
        pop_head();

        send(8'hE0);
        pulses = 0;
        for (int i = 0; i < TO + 5; i++) begin
            @(posedge CLOCK_50);
            #1 if (bus.prefix_timeout) pulses++;
        end
        send(8'h72);
`ifdef PS2_TIMEOUT_EN
        chk("timeout_pulses", pulses, 1);
        head("timeout_evt", 8'h72, 1'b0, 1'b0);
        chk("timeout_key", bus.key_r_dn, 1'b0);
`else
        chk("no_timeout_pulses", pulses, 0);
        head("no_timeout_evt", 8'h72, 1'b1, 1'b0);
        chk("no_timeout_key", bus.key_r_dn, 1'b1);
`endif
        pop_head();
        repeat (2) @(posedge CLOCK_50);
        #1 $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
